// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: FSM state encoding,
// the drain-length calculation and the FP16 zero used as a bubble value.
package systolic_skew_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_e;

    localparam logic [15:0] FP16_ZERO   = 16'h0000;
    localparam logic [15:0] K_COUNT_MAX = 16'hFFFF;

    // Cycles between the last accepted beat leaving the feeder and the
    // far-corner PE holding its final sum. Clamped to at least one cycle so
    // the drain counter always has something to count.
    function automatic int drain_cycles(input int arr_height, input int arr_width,
                                        input int pe_lat);
        int d_s;
        d_s = arr_height + arr_width + pe_lat - 32'sd2;
        if (d_s < 32'sd1) begin
            d_s = 32'sd1;
        end else begin
            d_s = d_s;
        end
        return d_s;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_lane_delay.sv
// Fixed-depth register delay line for one array-edge lane. The output is
// taken straight from the last stage register.
module lane_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift chain advancing every cycle; reset flushes every stage to zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skews unskewed A columns / B rows onto the west and north edges of a
// systolic array, inserts zero bubbles on idle cycles, and signals when the
// array accumulators are final after the last K-step of a job.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int PE_LAT     = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_last,
    input  logic [ARR_HEIGHT*WIDTH-1:0] s_a,
    input  logic [ARR_WIDTH*WIDTH-1:0]  s_b,
    output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
    output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
    output logic                        out_done_flag,
    output logic                        busy,
    output logic [15:0]                 k_count
);

    localparam logic [15:0] DRAIN_LEN = 16'(drain_cycles(ARR_HEIGHT, ARR_WIDTH, PE_LAT));

    feeder_state_e state_r;
    feeder_state_e next_state_s;

    logic        accept_s;
    logic        ready_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;
    logic        ready_r;
    logic        busy_r;
    logic        done_r;
    logic [15:0] drain_cnt_r;
    logic [15:0] k_count_r;

    logic [ARR_HEIGHT*WIDTH-1:0] a_feed_s;
    logic [ARR_WIDTH*WIDTH-1:0]  b_feed_s;

    assign accept_s = s_valid & ready_r;

    // State register; reset wins over any beat offered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: job start/continue on accepted beats, timed drain.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (s_last) begin
                        next_state_s = ST_DRAIN;
                    end else begin
                        next_state_s = ST_FEED;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_FEED: begin
                if (accept_s && s_last) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r <= 16'd1) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags can be registered
    // and still line up with the state they describe.
    always_comb begin
        ready_nxt_s = 1'b1;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        case (next_state_s)
            ST_IDLE: begin
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
            ST_FEED: begin
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
                done_nxt_s  = 1'b0;
            end
            ST_DRAIN: begin
                ready_nxt_s = 1'b0;
                busy_nxt_s  = 1'b1;
                done_nxt_s  = 1'b0;
            end
            ST_DONE: begin
                ready_nxt_s = 1'b0;
                busy_nxt_s  = 1'b1;
                done_nxt_s  = 1'b1;
            end
            default: begin
                ready_nxt_s = 1'b1;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Registered status outputs; reset returns to an idle, ready feeder.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // Drain down-counter: loaded on entry to DRAIN, counts to the DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt_r <= 16'd0;
        end else if ((state_r != ST_DRAIN) && (next_state_s == ST_DRAIN)) begin
            drain_cnt_r <= DRAIN_LEN;
        end else if ((state_r == ST_DRAIN) && (drain_cnt_r != 16'd0)) begin
            drain_cnt_r <= drain_cnt_r - 16'd1;
        end else begin
            drain_cnt_r <= drain_cnt_r;
        end
    end

    // Beat counter: restarts at 1 on a job's first beat, saturates, and
    // holds between jobs so software can read the final K.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_count_r <= 16'd0;
        end else if (accept_s && (state_r == ST_IDLE)) begin
            k_count_r <= 16'd1;
        end else if (accept_s && (state_r == ST_FEED) && (k_count_r != K_COUNT_MAX)) begin
            k_count_r <= k_count_r + 16'd1;
        end else begin
            k_count_r <= k_count_r;
        end
    end

    // Delay-line inputs: captured lane data on accepted beats, FP16 zero otherwise.
    always_comb begin
        if (accept_s) begin
            a_feed_s = s_a;
            b_feed_s = s_b;
        end else begin
            a_feed_s = {ARR_HEIGHT{WIDTH'(FP16_ZERO)}};
            b_feed_s = {ARR_WIDTH{WIDTH'(FP16_ZERO)}};
        end
    end

    // Lane i of either edge is delayed by i+1 cycles to form the wavefront.
    for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_a_lane
        lane_delay #(
            .WIDTH (WIDTH),
            .DEPTH (i + 1)
        ) u_a_delay (
            .clk   (clk),
            .reset (reset),
            .d     (a_feed_s[i*WIDTH +: WIDTH]),
            .q     (out_a[i*WIDTH +: WIDTH])
        );
    end

    for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_b_lane
        lane_delay #(
            .WIDTH (WIDTH),
            .DEPTH (j + 1)
        ) u_b_delay (
            .clk   (clk),
            .reset (reset),
            .d     (b_feed_s[j*WIDTH +: WIDTH]),
            .q     (out_b[j*WIDTH +: WIDTH])
        );
    end

    assign s_ready       = ready_r;
    assign busy          = busy_r;
    assign out_done_flag = done_r;
    assign k_count       = k_count_r;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder (H=W=4, PE_LAT=3, D=9).
// A time-based reference model predicts every output after every clock edge.
module tb_systolic_skew_feeder;

    localparam int D = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [63:0] s_a = 64'h0;
    logic [63:0] s_b = 64'h0;
    logic        s_ready;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic        out_done_flag;
    logic        busy;
    logic [15:0] k_count;

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .WIDTH(16), .ARR_HEIGHT(4), .ARR_WIDTH(4), .PE_LAT(3)
    ) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
        .s_last(s_last), .s_a(s_a), .s_b(s_b), .out_a(out_a), .out_b(out_b),
        .out_done_flag(out_done_flag), .busy(busy), .k_count(k_count)
    );

    int          checks = 0;
    int          errors = 0;
    // Reference model: what was fed into the edge at each clock edge, plus job timing.
    logic [63:0] ha [64];
    logic [63:0] hb [64];
    longint      edge_n = 0;
    longint      last_edge = -1000;
    bit          in_job = 1'b0;
    logic [15:0] k_m = 16'h0;
    bit          ready_m = 1'b1;
    bit          busy_m = 1'b0;
    bit          done_m = 1'b0;
    bit          model_ok = 1'b0;
    int          done_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_edge(input logic v, input logic l, input logic r,
                              input logic [63:0] a, input logic [63:0] b);
        bit acc;
        if (r) begin
            for (int i = 0; i < 64; i++) begin
                ha[i] = 64'h0;
                hb[i] = 64'h0;
            end
            in_job    = 1'b0;
            last_edge = -1000;
            k_m       = 16'h0;
            model_ok  = 1'b1;
        end else begin
            acc = v && ready_m;
            ha[int'(edge_n % 64)] = acc ? a : 64'h0;
            hb[int'(edge_n % 64)] = acc ? b : 64'h0;
            if (acc) begin
                if (in_job) k_m = (k_m == 16'hFFFF) ? k_m : k_m + 16'd1;
                else        k_m = 16'd1;
                if (l) begin
                    in_job    = 1'b0;
                    last_edge = edge_n;
                end else begin
                    in_job = 1'b1;
                end
            end
        end
        ready_m = !(edge_n >= last_edge && edge_n <= last_edge + D);
        busy_m  = in_job || (edge_n <= last_edge + D);
        done_m  = (edge_n == last_edge + D);
    endtask

    task automatic compare_all();
        logic [63:0] ea;
        logic [63:0] eb;
        for (int i = 0; i < 4; i++) begin
            ea[i*16 +: 16] = ha[int'((edge_n - i + 64) % 64)][i*16 +: 16];
            eb[i*16 +: 16] = hb[int'((edge_n - i + 64) % 64)][i*16 +: 16];
        end
        chk("out_a", out_a, ea);
        chk("out_b", out_b, eb);
        chk("done", out_done_flag, done_m);
        chk("busy", busy, busy_m);
        chk("s_ready", s_ready, ready_m);
        chk("k_count", k_count, k_m);
    endtask

    // One cycle: drive inputs, clock, advance model, compare away from the edge.
    task automatic step(input logic v, input logic l, input logic r,
                        input logic [63:0] a, input logic [63:0] b);
        reset = r; s_valid = v; s_last = l; s_a = a; s_b = b;
        @(posedge clk);
        model_edge(v, l, r, a, b);
        @(negedge clk);
        if (model_ok) compare_all();
        if (out_done_flag === 1'b1) done_seen++;
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) step(1'b0, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    initial begin : main
        logic [63:0] a1;
        logic [63:0] b1;
        a1 = {16'h3C03, 16'h3C02, 16'h3C01, 16'h3C00};
        b1 = {16'h4403, 16'h4402, 16'h4401, 16'h4400};
        @(negedge clk);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1, a1, b1);
        chk("rst_busy", busy, 64'h0);
        chk("rst_ready", s_ready, 64'h1);
        chk("rst_k", k_count, 64'h0);
        chk("rst_out_a", out_a, 64'h0);
        idle(2);

        // Single beat with s_last at cycle 0.
        step(1'b1, 1'b1, 1'b0, a1, b1);
        chk("single_a0_c1", out_a[15:0], 64'h3C00);
        idle(3);
        chk("single_a3_c4", out_a[63:48], 64'h3C03);
        idle(5);
        chk("single_nodone_c9", out_done_flag, 64'h0);
        idle(1);
        chk("single_done_c10", out_done_flag, 64'h1);
        chk("single_k", k_count, 64'h1);
        idle(1);
        chk("single_idle_c11", busy, 64'h0);

        // Four back-to-back beats, last at cycle 3.
        for (int k = 0; k < 4; k++) begin
            step(1'b1, (k == 3), 1'b0, {$urandom, $urandom}, {48'h0, 16'(16'h4000 + k)});
            chk("b2b_b0", out_b[15:0], 64'(16'h4000 + k));
        end
        idle(9);
        chk("b2b_done_c13", out_done_flag, 64'h1);
        chk("b2b_k", k_count, 64'h4);
        idle(2);

        // Bubble between two beats.
        step(1'b1, 1'b0, 1'b0, {48'h0, 16'h1111}, b1);
        step(1'b0, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        chk("bubble_a0_c2", out_a[15:0], 64'h0);
        step(1'b1, 1'b1, 1'b0, a1, b1);
        chk("bubble_k", k_count, 64'h2);
        idle(12);

        // s_valid held high through DRAIN and DONE.
        step(1'b1, 1'b1, 1'b0, a1, b1);
        chk("hold_ready_c1", s_ready, 64'h0);
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
            if (c <= 9) chk("hold_ready", s_ready, 64'h0);
        end
        chk("hold_k", k_count, 64'h1);
        chk("hold_flush_a", out_a, 64'h0);
        chk("hold_flush_b", out_b, 64'h0);
        idle(2);

        // Reset in the middle of DRAIN.
        step(1'b1, 1'b1, 1'b0, a1, b1);
        idle(4);
        step(1'b0, 1'b0, 1'b1, a1, b1);
        chk("rdrain_busy_c6", busy, 64'h0);
        chk("rdrain_a_c6", out_a, 64'h0);
        chk("rdrain_b_c6", out_b, 64'h0);
        done_seen = 0;
        idle(9);
        chk("rdrain_no_done", done_seen, 64'h0);

        // New job after DONE restarts k_count and keeps done timing.
        step(1'b1, 1'b0, 1'b0, a1, b1);
        step(1'b1, 1'b1, 1'b0, a1, b1);
        idle(11);
        step(1'b1, 1'b1, 1'b0, b1, a1);
        chk("restart_k", k_count, 64'h1);
        idle(9);
        chk("restart_done", out_done_flag, 64'h1);
        idle(2);

        // Randomized traffic, including offers during drain and rare resets.
        for (int c = 0; c < 3000; c++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 99) == 0), {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_skew_feeder.md
SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

Interface
REQ-001 Parameter WIDTH, default 16: element width in bits (FP16).
REQ-002 Parameter ARR_HEIGHT, default 4: array rows, which is also the number of A lanes.
REQ-003 Parameter ARR_WIDTH, default 4: array columns, which is also the number of B lanes.
REQ-004 Parameter PE_LAT, default 3: processing-element MAC latency in cycles.
REQ-005 Port clk, input, width 1: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset, input, width 1: synchronous, active-high reset.
REQ-007 Port s_valid, input, width 1: an input beat is present.
REQ-008 Port s_ready, output, width 1: the block can accept a beat.
REQ-009 Port s_last, input, width 1: the current beat is the final K-step of the job.
REQ-010 Port s_a, input, width ARR_HEIGHT*WIDTH: unskewed A column; lane i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
REQ-011 Port s_b, input, width ARR_WIDTH*WIDTH: unskewed B row; lane j uses the same packing as s_a.
REQ-012 Port out_a, output, width ARR_HEIGHT*WIDTH: skewed west-edge feed to the array.
REQ-013 Port out_b, output, width ARR_WIDTH*WIDTH: skewed north-edge feed to the array.
REQ-014 Port out_done_flag, output, width 1: single-cycle pulse marking that the array accumulators are final.
REQ-015 Port busy, output, width 1: high in every state except IDLE.
REQ-016 Port k_count, output, width 16: number of beats accepted in the current job, saturating at 0xFFFF.

Function
REQ-017 A beat SHALL be accepted on any cycle where s_valid and s_ready are both high.
REQ-018 s_ready SHALL be 1 in IDLE and FEED, and 0 in DRAIN and DONE.
REQ-019 A lanes SHALL be skewed: a value on lane i accepted at cycle T SHALL appear on out_a lane i at cycle T+1+i.
REQ-020 B lanes SHALL be skewed the same way: lane j accepted at T SHALL appear on out_b lane j at T+1+j.
REQ-021 Delay lines SHALL shift every cycle in every state; no back-pressure is applied to the array side.
REQ-022 On any cycle with no accepted beat, all lane inputs of the delay lines SHALL be loaded with 0x0000 (an FP16 zero bubble).
REQ-023 FSM states SHALL be IDLE, FEED, DRAIN and DONE.
REQ-024 IDLE: a beat accepted with s_last=0 SHALL transition to FEED; a beat accepted with s_last=1 SHALL transition to DRAIN.
REQ-025 FEED: a beat accepted with s_last=1 SHALL transition to DRAIN; any other cycle SHALL remain in FEED, with bubbles inserted per REQ-022.
REQ-026 DRAIN SHALL last exactly D = ARR_HEIGHT+ARR_WIDTH+PE_LAT-2 cycles, counted by a down-counter loaded on entry.
REQ-027 DONE SHALL last 1 cycle with out_done_flag=1, then transition to IDLE.
REQ-028 When the last beat is accepted at cycle T, out_done_flag SHALL be high at exactly cycle T+D+1.
REQ-029 k_count SHALL clear to 1 when a beat is accepted in IDLE, and increment on each beat accepted in FEED.
REQ-030 k_count SHALL hold its value through DRAIN, DONE and IDLE until the next job starts.
REQ-031 s_valid asserted during DRAIN or DONE SHALL be ignored, and the input data SHALL not be captured.
REQ-032 out_a and out_b SHALL be driven directly from registers, with no combinational path from s_a or s_b.

Reset
REQ-033 When reset=1 at a clock edge, the state SHALL become IDLE, all delay-line stages 0, k_count 0, and the drain counter 0.
REQ-034 On reset, out_a=0, out_b=0, out_done_flag=0, busy=0 and s_ready=1 SHALL take effect from the following cycle.
REQ-035 Reset during DRAIN SHALL suppress the pending out_done_flag pulse entirely.
REQ-036 reset SHALL take priority over a simultaneous beat acceptance.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, a function computing D from the parameters, and the FP16 zero constant.
REQ-038 The per-lane delay SHALL be a sub-module lane_delay with parameters WIDTH and DEPTH, instantiated once per lane with DEPTH = lane index + 1.

Verification
REQ-039 Verification SHALL run with H=W=4 and PE_LAT=3, so D=9, and cover the following directed scenarios.
REQ-040 Single beat: s_a lane i = 0x3C00+i with s_last=1 at cycle 0 -> out_a lane 3 = 0x3C03 at cycle 4; done pulse at cycle 10; k_count=1.
REQ-041 Four back-to-back beats, last at cycle 3 -> out_b lane 0 carries beats 0..3 on cycles 1..4; done pulse at cycle 13; k_count=4.
REQ-042 Bubble: s_valid low at cycle 1 between beats at cycles 0 and 2 -> out_a lane 0 = 0x0000 at cycle 2; k_count=2.
REQ-043 s_valid held high during DRAIN -> s_ready=0 throughout; k_count unchanged; outputs stay zero after the skew flushes.
REQ-044 Reset asserted at cycle T+5 of DRAIN -> no done pulse; busy=0 and all lanes 0 from T+6.
REQ-045 After DONE, a new beat accepted in IDLE -> k_count restarts at 1; done timing matches REQ-028.
